// File: rtl/relu_pack_pkg.sv
// Shared types and constants for the relu_pack stage.
package relu_pack_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int LANES = 4;
    localparam int SEL_W = 2;
    localparam int ZC_W  = 3;

endpackage

// File: rtl/relu_pack_relu_unit.sv
// Combinational ReLU on one signed lane, plus a flag for a zero result.
module relu_unit #(
    parameter int Pa = 8
) (
    input  logic [Pa-1:0] din,
    output logic [Pa-1:0] dout,
    output logic          is_zero
);

    // Negative lanes clamp to zero; non-negative lanes pass unchanged.
    always_comb begin
        dout    = din;
        is_zero = 1'b0;
        if (din[Pa-1]) begin
            dout = {Pa{1'b0}};
        end else begin
            dout = din;
        end
        is_zero = (dout == {Pa{1'b0}});
    end

endmodule

// File: rtl/relu_pack.sv
// Sweeps the upstream mux select, rectifies each lane and presents the packed
// word with a zero-lane count on a valid/ready output.
module relu_pack
    import relu_pack_pkg::*;
#(
    parameter int Pa = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic [SEL_W-1:0]  sel,
    input  logic [Pa-1:0]     in_mux,
    output logic [4*Pa-1:0]   out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ZC_W-1:0]   zero_cnt
);

    state_t                       state_r;
    state_t                       state_s;
    logic [SEL_W-1:0]             cnt_r;
    logic [SEL_W-1:0]             cnt_s;
    logic                         capture_s;
    logic                         final_s;
    logic [LANES-2:0][Pa-1:0]     lane_r;
    logic [ZC_W-1:0]              acc_r;
    logic [4*Pa-1:0]              out_data_r;
    logic [ZC_W-1:0]              zero_cnt_r;
    logic                         out_valid_r;
    logic                         busy_r;
    logic [Pa-1:0]                relu_s;
    logic                         is_zero_s;

    relu_unit #(.Pa(Pa)) u_relu (
        .din     (in_mux),
        .dout    (relu_s),
        .is_zero (is_zero_s)
    );

    // Next-state and lane-counter logic; counter rests at 0 outside SCAN so it doubles as sel.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        capture_s = 1'b0;
        final_s   = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_s = {SEL_W{1'b0}};
                if (start) begin
                    state_s = SCAN;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                capture_s = 1'b1;
                if (cnt_r == 2'd3) begin
                    state_s = HOLD;
                    final_s = 1'b1;
                    cnt_s   = {SEL_W{1'b0}};
                end else begin
                    state_s = SCAN;
                    cnt_s   = cnt_r + 2'd1;
                end
            end
            HOLD: begin
                cnt_s = {SEL_W{1'b0}};
                if (out_ready && start) begin
                    state_s = SCAN;
                end else if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {SEL_W{1'b0}};
            end
        endcase
    end

    // State, control outputs and lane capture; the output word only changes on the last lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {SEL_W{1'b0}};
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            lane_r      <= '0;
            acc_r       <= {ZC_W{1'b0}};
            out_data_r  <= {(4*Pa){1'b0}};
            zero_cnt_r  <= {ZC_W{1'b0}};
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            busy_r      <= (state_s != IDLE);
            out_valid_r <= (state_s == HOLD);
            if (final_s) begin
                out_data_r <= {relu_s, lane_r};
                zero_cnt_r <= acc_r + {{(ZC_W-1){1'b0}}, is_zero_s};
                acc_r      <= {ZC_W{1'b0}};
            end else if (capture_s) begin
                lane_r[cnt_r] <= relu_s;
                acc_r         <= acc_r + {{(ZC_W-1){1'b0}}, is_zero_s};
            end else begin
                acc_r <= {ZC_W{1'b0}};
            end
        end
    end

    assign sel       = cnt_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign zero_cnt  = zero_cnt_r;

endmodule
